lsu_bus_router: RTL
===================

Name: lsu_bus_router

Overview:
- Parametrised load/store unit for the RV32E core. Sits between the MEMEX/WB stages and the memory map.
- Decodes each request to one of four regions: CSR, DTCM, ITCM or external (SRAM-class). Generates byte-lane strobes, aligns and extends load data, and flags misaligned or unmapped accesses.
- Drives a req/ack handshake with a timeout to the slow external channel, and stalls the pipeline until that channel completes.

Parameters:
- CSR_BASE, 32'h0000, CSR window base; window size is fixed at 32'h1000.
- DTCM_BASE, 32'h1000, data TCM base.
- DTCM_SIZE, 32'h4000, data TCM size in bytes; must be a power of two.
- ITCM_BASE, 32'h5000, instruction TCM base.
- ITCM_SIZE, 32'h4000, instruction TCM size in bytes; must be a power of two.
- EXT_BASE, 32'h9000, external window base.
- EXT_SIZE, 32'h20000, external window size in bytes.
- TIMEOUT_CYCLES, 255, maximum number of ext_ack wait cycles before a fault (range 1..65535).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  access request, held by the core while stall=1
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_width  in  2  access width: 0=byte, 1=half, 2=word
- req_sign_extend  in  1  sign-extend load data
- stall  out  1  pipeline hold
- rsp_valid  out  1  load data or fault valid
- rsp_rdata  out  32  aligned and extended load data
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  0=none, 1=misaligned, 2=unmapped, 3=timeout
- mem_addr  out  32  request address, passed through to all targets
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- csr_we, csr_re  out  1 each  CSR strobes
- csr_rdata  in  32  CSR read data, combinational
- dtcm_we  out  1  DTCM write strobe
- dtcm_rdata  in  32  DTCM read data, 1-cycle synchronous RAM
- itcm_we  out  1  ITCM write strobe
- itcm_rdata  in  32  ITCM read data, 1-cycle synchronous RAM
- ext_req  out  1  external request, level
- ext_we  out  1  external write
- ext_ack  in  1  external completion
- ext_rdata  in  32  external read data, valid with ext_ack
- stall_cycles  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters cleared.
- Region decode uses half-open ranges [base, base+size). A request matching no region is unmapped.
- Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - Misaligned check takes priority over unmapped.
- Any fault:
  - no strobes are issued;
  - fault, fault_cause and rsp_valid assert for one cycle, in the cycle after the request;
  - rsp_rdata = 0.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data replication: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load data: raw word >> (8*addr[1:0]), then zero- or sign-extend from bit 7 (byte) or bit 15 (half).
- CSR, DTCM, ITCM accesses:
  - single-cycle issue, never stall;
  - we strobes are combinational in the request cycle;
  - loads complete with rsp_valid exactly 1 cycle later, from registered addr[1:0], width and sign flags.
- External FSM, states IDLE, WAIT, DONE:
  - IDLE -> WAIT on a valid, aligned ext request. ext_req and ext_we are registered, and stall=1 from the request cycle onward.
  - WAIT: ext_req held high; a 16-bit counter increments each cycle.
  - WAIT -> DONE on ext_ack. ext_rdata is captured, ext_req drops, stall is still 1.
  - WAIT -> DONE when the counter reaches TIMEOUT_CYCLES: fault_cause=3, ext_req drops.
  - DONE -> IDLE after one cycle. stall deasserts in DONE; rsp_valid and the captured data (or the timeout fault) are presented in DONE.
  - Minimum load latency is therefore 3 cycles.
- ext_ack in the same cycle the timeout is reached: ack wins, no fault.
- ext_ack outside WAIT is ignored.
- New requests are not accepted while the FSM is not IDLE; the core holds req_valid during stall.
- Asynchronous rst mid-transaction: FSM returns to IDLE, ext_req drops immediately, and no response is emitted.

Optional Feature:
- Macro LSU_STALL_COUNTER_EN.
- Defined: a 32-bit counter increments on every cycle with stall=1 and saturates at 32'hFFFFFFFF. It is cleared only by rst and drives stall_cycles.
- Undefined: the counter logic is absent and stall_cycles is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - width_e enum: BYTE=0, HALF=1, WORD=2;
  - fault_e enum: NONE, MISALIGN, UNMAPPED, TIMEOUT;
  - ext_state_e enum: IDLE, WAIT, DONE;
  - the default region base/size constants.
- Sub-module lsu_lane_align (purely combinational) holds byte-enable generation, store replication, and load shift/extend. It is instantiated once for stores and once for the load return path.

Test Plan:
- Store byte 0xA5 to 0x1003 -> dtcm_we=1, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, stall=0.
- Load half, signed, from 0x1002 with dtcm_rdata=0x8001_1234 -> next cycle rsp_valid=1, rsp_rdata=0xFFFF8001.
- Load word from 0x9004, ext_ack asserted 4 cycles after ext_req -> stall high 5 cycles, rsp_valid in DONE with ext_rdata.
- Load word from 0x9000, ext_ack never asserted, TIMEOUT_CYCLES=8 -> fault=1, fault_cause=3 after the 8th wait cycle, ext_req low.
- Word to 0x1002 -> fault_cause=1, no strobes. Word to 0x30000 -> fault_cause=2.
- rst asserted in WAIT -> ext_req=0 in the same cycle, stall=0, no rsp_valid; with LSU_STALL_COUNTER_EN, stall_cycles returns to 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and default memory map for the lsu_bus_router slice.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } width_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        UNMAPPED = 2'd2,
        TIMEOUT  = 2'd3
    } fault_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ext_state_e;

    typedef enum logic [2:0] {
        RGN_NONE = 3'd0,
        RGN_CSR  = 3'd1,
        RGN_DTCM = 3'd2,
        RGN_ITCM = 3'd3,
        RGN_EXT  = 3'd4
    } region_e;

    localparam logic [31:0] CSR_SIZE      = 32'h0000_1000;
    localparam logic [31:0] DEF_CSR_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_DTCM_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_DTCM_SIZE = 32'h0000_4000;
    localparam logic [31:0] DEF_ITCM_BASE = 32'h0000_5000;
    localparam logic [31:0] DEF_ITCM_SIZE = 32'h0000_4000;
    localparam logic [31:0] DEF_EXT_BASE  = 32'h0000_9000;
    localparam logic [31:0] DEF_EXT_SIZE  = 32'h0002_0000;

    // Half-open window test done in 33 bits so base+size cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane helper. Produces byte enables and replicated
// store data from the request, and shifts/extends a raw 32-bit read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  offset_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Lane selection for stores and right-justify/extend for loads
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (width_i)
            BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_router.sv
// lsu_bus_router: RV32E load/store router. Decodes CSR/DTCM/ITCM/external
// regions, drives byte lanes, returns aligned load data and runs the
// req/ack handshake with timeout on the external channel.
// Optional build macro LSU_STALL_COUNTER_EN adds a saturating stall-cycle
// counter on stall_cycles; without it stall_cycles is tied to zero.
module lsu_bus_router
    import lsu_pkg::*;
#(
    parameter logic [31:0] CSR_BASE       = DEF_CSR_BASE,
    parameter logic [31:0] DTCM_BASE      = DEF_DTCM_BASE,
    parameter logic [31:0] DTCM_SIZE      = DEF_DTCM_SIZE,
    parameter logic [31:0] ITCM_BASE      = DEF_ITCM_BASE,
    parameter logic [31:0] ITCM_SIZE      = DEF_ITCM_SIZE,
    parameter logic [31:0] EXT_BASE       = DEF_EXT_BASE,
    parameter logic [31:0] EXT_SIZE       = DEF_EXT_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_sign_extend,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        csr_we,
    output logic        csr_re,
    input  logic [31:0] csr_rdata,
    output logic        dtcm_we,
    input  logic [31:0] dtcm_rdata,
    output logic        itcm_we,
    input  logic [31:0] itcm_rdata,
    output logic        ext_req,
    output logic        ext_we,
    input  logic        ext_ack,
    input  logic [31:0] ext_rdata,
    output logic [31:0] stall_cycles
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    region_e     region;
    logic        misalign;
    logic        accept;
    logic        req_fault;
    logic        issue;
    logic        issue_ext;

    ext_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic        timeout_q, timeout_d;
    logic        pend_q, pend_d;
    fault_e      rfault_q, rfault_d;

    logic [1:0]  off_q;
    logic [1:0]  width_q;
    logic        sign_q;
    logic        we_q;
    region_e     src_q;
    logic [31:0] csr_data_q;
    logic [31:0] ext_data_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_raw;
    logic [31:0] ld_rdata;
    fault_e      cause;
    logic        done_rsp;

    logic [31:0] unused_st_rdata;
    logic [3:0]  unused_ld_be;
    logic [31:0] unused_ld_wdata;

    // Region decode, first match wins on the half-open windows
    always_comb begin
        region = RGN_NONE;
        if (in_window(req_addr, CSR_BASE, CSR_SIZE))        region = RGN_CSR;
        else if (in_window(req_addr, DTCM_BASE, DTCM_SIZE)) region = RGN_DTCM;
        else if (in_window(req_addr, ITCM_BASE, ITCM_SIZE)) region = RGN_ITCM;
        else if (in_window(req_addr, EXT_BASE, EXT_SIZE))   region = RGN_EXT;
    end

    // Natural-alignment check on the requested width
    always_comb begin
        case (req_width)
            BYTE:    misalign = 1'b0;
            HALF:    misalign = req_addr[0];
            default: misalign = |req_addr[1:0];
        endcase
    end

    // Reset gating keeps stall and strobes low while rst is high even if
    // the core is still holding its request.
    assign accept    = req_valid && !rst && (state_q == IDLE);
    assign req_fault = misalign || (region == RGN_NONE);
    assign issue     = accept && !req_fault;
    assign issue_ext = issue && (region == RGN_EXT);

    lsu_lane_align u_store_lanes (
        .width_i  (req_width),
        .offset_i (req_addr[1:0]),
        .sign_i   (1'b0),
        .wdata_i  (req_wdata),
        .rdata_i  (32'h0),
        .be_o     (st_be),
        .wdata_o  (st_wdata),
        .rdata_o  (unused_st_rdata)
    );

    assign stall     = issue_ext || (state_q == WAIT);
    assign mem_addr  = req_addr;
    assign mem_be    = (issue || state_q == WAIT) ? st_be : 4'b0000;
    assign mem_wdata = (issue || state_q == WAIT) ? st_wdata : 32'h0;
    assign csr_we    = issue && req_we  && (region == RGN_CSR);
    assign csr_re    = issue && !req_we && (region == RGN_CSR);
    assign dtcm_we   = issue && req_we  && (region == RGN_DTCM);
    assign itcm_we   = issue && req_we  && (region == RGN_ITCM);
    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;

    // External FSM next state plus single-cycle response/fault scheduling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ext_req_d = ext_req_q;
        ext_we_d  = ext_we_q;
        timeout_d = timeout_q;
        pend_d    = issue && !req_we && (region != RGN_EXT);
        rfault_d  = NONE;
        if (accept && req_fault) rfault_d = misalign ? MISALIGN : UNMAPPED;
        case (state_q)
            IDLE: begin
                if (issue_ext) begin
                    state_d   = WAIT;
                    cnt_d     = '0;
                    ext_req_d = 1'b1;
                    ext_we_d  = req_we;
                    timeout_d = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (ext_ack) begin
                    state_d   = DONE;
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = DONE;
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, cleared asynchronously so ext_req drops at once on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ext_req_q <= 1'b0;
            ext_we_q  <= 1'b0;
            timeout_q <= 1'b0;
            pend_q    <= 1'b0;
            rfault_q  <= NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ext_req_q <= ext_req_d;
            ext_we_q  <= ext_we_d;
            timeout_q <= timeout_d;
            pend_q    <= pend_d;
            rfault_q  <= rfault_d;
        end
    end

    // Request attributes and returned data held for the response cycle
    always_ff @(posedge clk) begin
        if (issue) begin
            off_q      <= req_addr[1:0];
            width_q    <= req_width;
            sign_q     <= req_sign_extend;
            we_q       <= req_we;
            src_q      <= region;
            csr_data_q <= csr_rdata;
        end
        if (state_q == WAIT && ext_ack) ext_data_q <= ext_rdata;
    end

    // Pick the raw word for the response source
    always_comb begin
        case (src_q)
            RGN_CSR:  ld_raw = csr_data_q;
            RGN_DTCM: ld_raw = dtcm_rdata;
            RGN_ITCM: ld_raw = itcm_rdata;
            default:  ld_raw = ext_data_q;
        endcase
    end

    lsu_lane_align u_load_lanes (
        .width_i  (width_q),
        .offset_i (off_q),
        .sign_i   (sign_q),
        .wdata_i  (32'h0),
        .rdata_i  (ld_raw),
        .be_o     (unused_ld_be),
        .wdata_o  (unused_ld_wdata),
        .rdata_o  (ld_rdata)
    );

    // Response and fault outputs; data forced to zero unless a clean load
    always_comb begin
        done_rsp = (state_q == DONE) && (timeout_q || !we_q);
        cause    = rfault_q;
        if (state_q == DONE && timeout_q) cause = TIMEOUT;
        rsp_valid   = pend_q || (rfault_q != NONE) || done_rsp;
        fault       = (cause != NONE);
        fault_cause = cause;
        rsp_rdata   = (rsp_valid && !fault) ? ld_rdata : 32'h0;
    end

`ifdef LSU_STALL_COUNTER_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles spent with the pipeline held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule
